// File: rtl/t_vpi_var_pkg.sv
// Shared types for the VPI variable-model stimulus sequencer: the packed
// structs the monitor inspects, the sequencer state enum and the per-step
// value pattern.
package t_vpi_var_pkg;

    typedef struct packed {
        logic       s_field;
        logic [2:0] p_field;
    } struct_test;

    typedef struct packed {
        struct_test field0;
        logic [2:0] p_field;
        struct_test field1;
    } outer_struct;

    typedef union packed {
        struct_test st;
        logic [3:0] raw;
    } union_test;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_PRESENT  = 3'd2,
        ST_WAIT_LOW = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

    // Everything presented for one step, in port order.
    typedef struct packed {
        struct_test       s;
        outer_struct      s_emb;
        struct_test [1:0] s_p1;
        logic [2:0][1:0]  a_p21;
    } pattern_t;

    // Only the low three step bits shape the pattern, so the caller passes k[2:0].
    function automatic pattern_t pattern_step(input logic [2:0] k);
        pattern_t p;
        p.s.s_field      = k[0];
        p.s.p_field      = k;
        p.s_p1[1]        = p.s;
        p.s_p1[0]        = ~p.s;
        p.s_emb.field0   = p.s;
        p.s_emb.p_field  = k + 3'd1;
        p.s_emb.field1   = ~p.s;
        p.a_p21[2]       = k[1:0];
        p.a_p21[1]       = k[1:0] ^ 2'b11;
        p.a_p21[0]       = 2'b10;
        return p;
    endfunction

endpackage

// File: rtl/t_vpi_var_stim_if.sv
// Handshake and data bundle between the stimulus sequencer (master) and the
// VPI-sampled consumer (slave). csum exists only with T_VPI_STIM_CHECKSUM_EN.
interface t_vpi_var_stim_if;
    import t_vpi_var_pkg::*;

    logic             start;
    logic             ack;
    logic             valid;
    logic [3:0]       step;
    struct_test       s;
    outer_struct      s_emb;
    struct_test [1:0] s_p1;
    logic [2:0][1:0]  a_p21;
    logic             done;
    logic             err;
`ifdef T_VPI_STIM_CHECKSUM_EN
    logic [10:0]      csum;

    modport master (input start, ack,
                    output valid, step, s, s_emb, s_p1, a_p21, done, err, csum);
    modport slave  (output start, ack,
                    input valid, step, s, s_emb, s_p1, a_p21, done, err, csum);
`else
    modport master (input start, ack,
                    output valid, step, s, s_emb, s_p1, a_p21, done, err);
    modport slave  (output start, ack,
                    input valid, step, s, s_emb, s_p1, a_p21, done, err);
`endif
endinterface

// File: rtl/t_vpi_var_tmo.sv
// Saturating up-counter measuring how long valid has waited for ack.
// expired is high once the count reaches TIMEOUT-1.
module t_vpi_var_tmo #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int            W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [W-1:0]  LAST = W'(TIMEOUT - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Clear wins over count; counting stops at LAST.
    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en && (cnt_q != LAST))
            cnt_d = cnt_q + 1'b1;
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign expired = (cnt_q == LAST);

endmodule

// File: rtl/t_vpi_var_stim.sv
// Handshaked stimulus sequencer for the VPI variable-model monitor.
// Optional checksum output enabled by T_VPI_STIM_CHECKSUM_EN.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   IDLE      | waiting for start
//   LOAD      | register pattern for step onto data outputs
//   PRESENT   | valid high, waiting for ack or timeout
//   WAIT_LOW  | ack seen, waiting for ack to drop
//   DONE      | run finished, outputs held, start restarts
//
// All outputs are registered from the current state, so valid/done trail the
// state by one edge; err is piped one extra stage so it rises with done.
module t_vpi_var_stim
    import t_vpi_var_pkg::*;
#(
    parameter int NUM_STEPS = 8,
    parameter int TIMEOUT   = 16
) (
    input  logic              clk,
    input  logic              reset,
    t_vpi_var_stim_if.master  bus
);
    localparam logic [3:0] LAST_STEP = 4'(NUM_STEPS - 1);

    state_e     state_q, state_d;
    logic [3:0] step_q;
    pattern_t   pat_q;
    logic       valid_q, done_q, tmo_q, err_q;
    logic       tmo_expired;
    logic       last_step;
    logic       run_start, load_en, advance, timeout_hit, tmo_en;

    assign last_step = (step_q == LAST_STEP);

    t_vpi_var_tmo #(.TIMEOUT(TIMEOUT)) u_tmo (
        .clk     (clk),
        .reset   (reset),
        .clr     (load_en),
        .en      (tmo_en),
        .expired (tmo_expired)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (bus.start) state_d = ST_LOAD;
            ST_LOAD:     state_d = ST_PRESENT;
            ST_PRESENT: begin
                if (bus.ack)
                    state_d = ST_WAIT_LOW;
                else if (tmo_expired)
                    state_d = ST_DONE;
            end
            ST_WAIT_LOW: if (!bus.ack) state_d = last_step ? ST_DONE : ST_LOAD;
            ST_DONE:     if (bus.start) state_d = ST_LOAD;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Per-state control strobes feeding the output registers.
    always_comb begin
        run_start   = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && bus.start;
        load_en     = (state_q == ST_LOAD);
        tmo_en      = (state_q == ST_PRESENT);
        advance     = (state_q == ST_WAIT_LOW) && !bus.ack && !last_step;
        timeout_hit = (state_q == ST_PRESENT) && !bus.ack && tmo_expired;
    end

    // Output registers: data changes only while leaving LOAD.
    always_ff @(posedge clk) begin
        if (reset) begin
            step_q  <= '0;
            pat_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= (state_q == ST_PRESENT);
            done_q  <= (state_q == ST_DONE);
            err_q   <= tmo_q;
            if (run_start)
                step_q <= '0;
            else if (advance)
                step_q <= step_q + 4'd1;
            if (run_start)
                tmo_q <= 1'b0;
            else if (timeout_hit)
                tmo_q <= 1'b1;
            if (load_en)
                pat_q <= pattern_step(step_q[2:0]);
        end
    end

`ifdef T_VPI_STIM_CHECKSUM_EN
    logic [10:0] csum_q;

    // Fold the presented s_emb into the checksum on every accepted handshake.
    always_ff @(posedge clk) begin
        if (reset || run_start)
            csum_q <= '0;
        else if ((state_q == ST_PRESENT) && bus.ack)
            csum_q <= csum_q ^ pat_q.s_emb;
    end

    assign bus.csum = csum_q;
`endif

    assign bus.valid = valid_q;
    assign bus.done  = done_q;
    assign bus.err   = err_q;
    assign bus.step  = step_q;
    assign bus.s     = pat_q.s;
    assign bus.s_emb = pat_q.s_emb;
    assign bus.s_p1  = pat_q.s_p1;
    assign bus.a_p21 = pat_q.a_p21;

endmodule

// File: tb/tb_t_vpi_var_stim.sv
// Bench for the VPI stimulus sequencer: main instance with NUM_STEPS=8 and
// TIMEOUT=4; a NUM_STEPS=2 instance exercises the checksum when
// T_VPI_STIM_CHECKSUM_EN is defined.
module tb_t_vpi_var_stim;
    import t_vpi_var_pkg::*;

    typedef struct packed {
        logic [3:0]  step;
        logic [28:0] data;
    } exp_t;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;
    exp_t sb[$];

    t_vpi_var_stim_if bus ();
    t_vpi_var_stim #(.NUM_STEPS(8), .TIMEOUT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

`ifdef T_VPI_STIM_CHECKSUM_EN
    t_vpi_var_stim_if bus2 ();
    t_vpi_var_stim #(.NUM_STEPS(2), .TIMEOUT(16)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference pattern written straight from the step formula.
    function automatic logic [28:0] model_pattern(input int k);
        logic [2:0] k3;
        logic [1:0] k2;
        logic [3:0] sv;
        k3 = k[2:0];
        k2 = k[1:0];
        sv = {k3[0], k3};
        return {sv, sv, 3'(k3 + 3'd1), ~sv, sv, ~sv, k2, k2 ^ 2'b11, 2'b10};
    endfunction

    function automatic logic [28:0] obs_data();
        return {bus.s, bus.s_emb, bus.s_p1, bus.a_p21};
    endfunction

    task automatic start_pulse();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic ack_pulse();
        bus.ack = 1'b1;
        @(negedge clk);
        bus.ack = 1'b0;
    endtask

    // Returns the number of negedges until valid is seen, or -1 on budget expiry.
    task automatic wait_valid(output int n);
        n = 0;
        forever begin
            @(negedge clk);
            n++;
            if (bus.valid === 1'b1) break;
            if (n >= 40) begin
                n = -1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0;
        bus.ack = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({bus.valid, bus.done, bus.err, bus.step} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b, expected 0", {bus.valid, bus.done, bus.err, bus.step});
        end
        vectors++;
        if (obs_data() !== 29'b0) begin
            miscompares++;
            $display("FAIL reset_data: got %h, expected 0", obs_data());
        end
        vectors++;
        if (dut.state_q !== ST_IDLE) begin
            miscompares++;
            $display("FAIL reset_state: got %0d, expected IDLE", dut.state_q);
        end
`ifdef T_VPI_STIM_CHECKSUM_EN
        vectors++;
        if (bus.csum !== 11'h000) begin
            miscompares++;
            $display("FAIL reset_csum: got %h, expected 000", bus.csum);
        end
`endif
        reset = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.valid !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_no_start: valid=%b, expected 0", bus.valid);
        end
    endtask

    task automatic test_reset_mid_run();
        int n;
        start_pulse();
        for (int k = 0; k < 3; k++) begin
            wait_valid(n);
            vectors++;
            if (n < 0 || bus.step !== 4'(k)) begin
                miscompares++;
                $display("FAIL midrun_reach_step%0d: wait=%0d step=%0d", k, n, bus.step);
            end
            if (k < 2) ack_pulse();
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vectors++;
        if ({bus.valid, bus.step, bus.s, bus.done, bus.err} !== 11'b0) begin
            miscompares++;
            $display("FAIL midrun_reset_outputs: got %b, expected 0",
                     {bus.valid, bus.step, bus.s, bus.done, bus.err});
        end
        vectors++;
        if (dut.state_q !== ST_IDLE) begin
            miscompares++;
            $display("FAIL midrun_reset_state: got %0d, expected IDLE", dut.state_q);
        end
    endtask

    task automatic test_basic_handshake();
        int   n;
        exp_t e;
        sb.push_back('{step: 4'd0, data: model_pattern(0)});
        start_pulse();
        @(negedge clk);
        vectors++;
        if (bus.valid !== 1'b0 || obs_data() !== model_pattern(0)) begin
            miscompares++;
            $display("FAIL basic_load_timing: valid=%b data=%h, expected valid 0 data %h",
                     bus.valid, obs_data(), model_pattern(0));
        end
        @(negedge clk);
        vectors++;
        if (bus.valid !== 1'b1) begin
            miscompares++;
            $display("FAIL basic_valid_rise: valid=%b, expected 1", bus.valid);
        end
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                wait_valid(n);
                vectors++;
                if (n !== 3) begin
                    miscompares++;
                    $display("FAIL basic_next_latency: got %0d cycles, expected 3", n);
                end
            end
            e = sb.pop_front();
            vectors++;
            if ({bus.step, obs_data()} !== e) begin
                miscompares++;
                $display("FAIL basic_step%0d: got %h, expected %h", k, {bus.step, obs_data()}, e);
            end
            if (k == 3) begin
                vectors++;
                if ({bus.s, bus.s_p1, bus.s_emb, bus.a_p21, bus.step} !==
                    {4'hB, 8'hB4, 11'h5C4, 6'h32, 4'd3}) begin
                    miscompares++;
                    $display("FAIL basic_step3_fields: s=%h s_p1=%h s_emb=%h a_p21=%h step=%0d, expected B B4 5C4 32 3",
                             bus.s, bus.s_p1, bus.s_emb, bus.a_p21, bus.step);
                end
            end
            sb.push_back('{step: 4'(k + 1), data: model_pattern(k + 1)});
            ack_pulse();
        end
        @(negedge clk);
        vectors++;
        if (bus.valid !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_valid_drop: valid=%b, expected 0", bus.valid);
        end
        do_reset();
    endtask

    task automatic test_full_run();
        int   n;
        exp_t e;
        sb.push_back('{step: 4'd0, data: model_pattern(0)});
        start_pulse();
        for (int k = 0; k < 8; k++) begin
            wait_valid(n);
            vectors++;
            if (n !== ((k == 0) ? 2 : 3)) begin
                miscompares++;
                $display("FAIL full_latency_step%0d: got %0d, expected %0d", k, n, (k == 0) ? 2 : 3);
            end
            e = sb.pop_front();
            vectors++;
            if ({bus.step, obs_data()} !== e) begin
                miscompares++;
                $display("FAIL full_step%0d: got %h, expected %h", k, {bus.step, obs_data()}, e);
            end
            if (k < 7) sb.push_back('{step: 4'(k + 1), data: model_pattern(k + 1)});
            ack_pulse();
        end
        @(negedge clk);
        vectors++;
        if (bus.done !== 1'b0 || bus.valid !== 1'b0) begin
            miscompares++;
            $display("FAIL full_done_early: done=%b valid=%b, expected 0 0", bus.done, bus.valid);
        end
        @(negedge clk);
        vectors++;
        if ({bus.done, bus.err, bus.step} !== {1'b1, 1'b0, 4'd7} || obs_data() !== model_pattern(7)) begin
            miscompares++;
            $display("FAIL full_done: done=%b err=%b step=%0d data=%h, expected 1 0 7 %h",
                     bus.done, bus.err, bus.step, obs_data(), model_pattern(7));
        end
        vectors++;
        if (sb.size() !== 0) begin
            miscompares++;
            $display("FAIL full_sb_empty: %0d left, expected 0", sb.size());
        end
    endtask

    // Entered from DONE, so the start here also covers restart-from-DONE.
    task automatic test_held_ack();
        int n;
        start_pulse();
        wait_valid(n);
        vectors++;
        if (n !== 2 || bus.step !== 4'd0) begin
            miscompares++;
            $display("FAIL held_restart: wait=%0d step=%0d, expected 2 0", n, bus.step);
        end
        bus.ack = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            if (i == 3) bus.start = 1'b1;
            if (i == 4) bus.start = 1'b0;
            @(negedge clk);
            if (i >= 2) begin
                vectors++;
                if (bus.valid !== 1'b0 || bus.step !== 4'd0 || dut.state_q !== ST_WAIT_LOW) begin
                    miscompares++;
                    $display("FAIL held_wait_low_%0d: valid=%b step=%0d state=%0d, expected 0 0 WAIT_LOW",
                             i, bus.valid, bus.step, dut.state_q);
                end
            end
        end
        bus.ack = 1'b0;
        wait_valid(n);
        vectors++;
        if (n !== 3 || bus.step !== 4'd1 || obs_data() !== model_pattern(1)) begin
            miscompares++;
            $display("FAIL held_release: wait=%0d step=%0d data=%h, expected 3 1 %h",
                     n, bus.step, obs_data(), model_pattern(1));
        end
        do_reset();
    endtask

    task automatic test_ack_on_entry();
        start_pulse();
        bus.ack = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (bus.valid !== 1'b1 || dut.state_q !== ST_WAIT_LOW) begin
            miscompares++;
            $display("FAIL entry_ack_accept: valid=%b state=%0d, expected 1 WAIT_LOW", bus.valid, dut.state_q);
        end
        bus.ack = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.valid !== 1'b0) begin
            miscompares++;
            $display("FAIL entry_ack_drop: valid=%b, expected 0", bus.valid);
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (bus.valid !== 1'b1 || bus.step !== 4'd1) begin
            miscompares++;
            $display("FAIL entry_ack_next: valid=%b step=%0d, expected 1 1", bus.valid, bus.step);
        end
        do_reset();
    endtask

    task automatic test_timeout();
        int n;
        start_pulse();
        wait_valid(n);
        vectors++;
        if (n !== 2) begin
            miscompares++;
            $display("FAIL tmo_valid_rise: got %0d, expected 2", n);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (bus.err !== 1'b0 || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL tmo_early: err=%b done=%b, expected 0 0", bus.err, bus.done);
        end
        @(negedge clk);
        vectors++;
        if ({bus.err, bus.done, bus.valid} !== 3'b110) begin
            miscompares++;
            $display("FAIL tmo_fire: err/done/valid=%b, expected 110", {bus.err, bus.done, bus.valid});
        end
        repeat (4) @(negedge clk);
        vectors++;
        if (bus.err !== 1'b1) begin
            miscompares++;
            $display("FAIL tmo_sticky: err=%b, expected 1", bus.err);
        end
        start_pulse();
        @(negedge clk);
        vectors++;
        if (bus.err !== 1'b0) begin
            miscompares++;
            $display("FAIL tmo_clear_on_start: err=%b, expected 0", bus.err);
        end
        do_reset();
    endtask

`ifdef T_VPI_STIM_CHECKSUM_EN
    task automatic test_checksum();
        int n;
        bus2.start = 1'b1;
        @(negedge clk);
        bus2.start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n = 0;
            while (bus2.valid !== 1'b1 && n < 40) begin
                @(negedge clk);
                n++;
            end
            vectors++;
            if (bus2.valid !== 1'b1) begin
                miscompares++;
                $display("FAIL csum_valid_step%0d: valid never rose", k);
            end
            bus2.ack = 1'b1;
            @(negedge clk);
            bus2.ack = 1'b0;
            if (k == 0) begin
                vectors++;
                if (bus2.csum !== 11'h01F) begin
                    miscompares++;
                    $display("FAIL csum_step0: got %h, expected 01F", bus2.csum);
                end
            end
            @(negedge clk);
        end
        n = 0;
        while (bus2.done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (bus2.done !== 1'b1 || bus2.csum !== 11'h4B9) begin
            miscompares++;
            $display("FAIL csum_done: done=%b csum=%h, expected 1 4B9", bus2.done, bus2.csum);
        end
    endtask
`endif

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.ack = 1'b0;
`ifdef T_VPI_STIM_CHECKSUM_EN
        bus2.start = 1'b0;
        bus2.ack = 1'b0;
`endif
        test_reset();
        test_reset_mid_run();
        test_basic_handshake();
        test_full_run();
        test_held_ack();
        test_ack_on_entry();
        test_timeout();
`ifdef T_VPI_STIM_CHECKSUM_EN
        test_checksum();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/t_vpi_var_stim.md
# t_vpi_var_stim

Stimulus sequencer that drives the public packed-struct and packed-array variables sampled by the VPI variable-model monitor. It sits directly upstream of the monitor. It walks a deterministic value pattern one step at a time and presents each step with `valid`. It then waits for the C side to acknowledge through a `public_flat_rw` signal before advancing. This gives the VPI test a cycle-exact, handshaked view of struct fields, embedded structs and multi-dimensional packed arrays.

## Interface
Parameters:
- `NUM_STEPS`, default 8: pattern steps per run; legal range 1..16.
- `TIMEOUT`, default 16: cycles `valid` may stay high without ack before abort; must be ≥2.

Ports:
- `clk` in 1: the only clock; all state changes on posedge.
- `reset` in 1: reset is synchronous and active-high.
- `start` in 1: single-cycle run request.
- `ack` in 1: consumer acknowledge; written by VPI, `public_flat_rw @(posedge clk)`.
- `valid` out 1: current step outputs are stable and ready to be read.
- `step` out 4: index of the presented step.
- `s` out 4: `struct_test` (`s_field`, `p_field[2:0]`).
- `s_emb` out 11: `outer_struct` (`field0`, `p_field[2:0]`, `field1`).
- `s_p1` out 8: `struct_test [1:0]`.
- `a_p21` out 6: `logic [2:0][1:0]`.
- `done` out 1: run finished, either normally or by timeout.
- `err` out 1: sticky timeout flag.
- `csum` out 11: checksum; present only with the macro described under Configuration.

## Operation
- States: IDLE, LOAD, PRESENT, WAIT_LOW, DONE. Encoding is a 3-bit enum.
- IDLE: when `start` is high, go to LOAD with step=0 and clear `err`. Otherwise stay in IDLE.
- LOAD: register the pattern for `step` onto the data outputs, then go to PRESENT.
- PRESENT: `valid`=1 and the timeout counter increments each cycle.
  - If `ack` is high, go to WAIT_LOW.
  - Else, if the timeout counter reaches TIMEOUT-1, set `err` and go to DONE.
- WAIT_LOW: `valid`=0; wait for `ack` to go low.
  - If step==NUM_STEPS-1, go to DONE.
  - Otherwise increment step and go to LOAD.
- DONE: `done`=1 and the data outputs hold their last values. `start` here restarts the run exactly as from IDLE.
- `start` is ignored in LOAD, PRESENT and WAIT_LOW.
- Pattern for step k, with k3 = k[2:0]:
  - `s.s_field` = k[0], `s.p_field` = k3.
  - `s_p1` = {s, ~s}.
  - `s_emb` = {s, k3+1 (mod 8), ~s}.
  - `a_p21` = {k[1:0], k[1:0]^2'b11, 2'b10}.
- Width rules: `step` is 4 bits and never exceeds NUM_STEPS-1. The timeout counter is $clog2(TIMEOUT) bits and saturates.

## Timing
- Reset values: every output is 0 and the state is IDLE. This applies to `s`, `s_emb`, `s_p1`, `a_p21`, `step`, `valid`, `done`, `err` and `csum`.
- Reset asserted in any state returns the block to IDLE on the next edge and takes priority over every other input.
- Start sampled at edge N: outputs are loaded at N+1, and `valid`=1 from N+2.
- `ack` sampled high at edge M: `valid`=0 from M+1.
  - `ack` low at edge M+1: the next step's `valid` rises at M+3.
  - `ack` low at M+1 on the final step: `done` rises at M+2.
- `ack` already high on entry to PRESENT is accepted in the first PRESENT cycle.
- The timeout counter clears on entry to PRESENT. It counts only while in PRESENT.
- The data outputs change only at the LOAD→PRESENT edge. They are stable for the whole time `valid` is high.

## Configuration
- Macro `T_VPI_STIM_CHECKSUM_EN`.
- Defined: `csum` is an 11-bit register that XORs in `s_emb` on each accepted handshake (PRESENT with `ack` high). It clears on reset and on a run start. It holds its value in DONE.
- Undefined: the `csum` port and its register are absent, and all other behaviour is identical.

## Structure
- Package `t_vpi_var_pkg` holds:
  - `struct_test`, `outer_struct` and `union_test` typedefs.
  - The state enum.
  - A `pattern_step(k)` function returning {s, s_emb, s_p1, a_p21}.
- Sub-module `t_vpi_var_tmo` holds the timeout counter. Its inputs are `clk`, `reset` and `clr`/`en`; its output is `expired`.
- The FSM and output registers live in the top module.

## Test plan
- Reset mid-run: assert `reset` during PRESENT of step 2. Required: `valid`=0, `step`=0, `s`=0, `done`=0, `err`=0 after one edge, and the state is IDLE.
- Basic handshake: `start`, then acknowledge step 3 with ack high for 1 cycle. Required while presented: `s`=4'hB, `s_p1`=8'hB4, `s_emb`=11'h5C4, `a_p21`=6'h32, `step`=3.
- Full run: NUM_STEPS=8, ack every step. Required: `done`=1 two edges after the final ack-low, `step`=7, `err`=0.
- Timeout: TIMEOUT=4 with `ack` held low. Required: `err`=1 and `done`=1 four cycles after `valid` rises; `err` stays high until the next `start`.
- Held ack: keep `ack` high for 5 cycles on step 0. Required: the block stays in WAIT_LOW with `valid`=0 and step 1 is not presented until `ack` falls. `start` pulsed meanwhile is ignored.
- Checksum (macro defined): NUM_STEPS=2, both steps acknowledged. Required: `csum`=11'h01F after step 0 and 11'h4B9 at `done`.
